hilo_ctrl: RTL and testbench
============================

Name: hilo_ctrl

Overview:
- Issue-and-writeback controller for the HI/LO special registers, sitting between the EX stage and the multiply/divide datapath.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from EX and launches operations into the mult/div unit.
- Tracks in-flight latency, captures the unit's hi/lo results into architectural HI/LO, and stalls the pipeline while results are pending.

Parameters:
- MUL_LAT, 5: cycles from mult issue edge to HI/LO capture edge (range 1..15).
- DIV_MAX, 40: watchdog; DIV state aborts to IDLE after this many cycles without md_div_done.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  cancel in-flight op (exception/ERET)
- ex_valid  in  1  EX instruction valid
- ex_op  in  4  hilo_op_t encoding
- ex_rs  in  32  operand A / MTHI/MTLO data
- ex_rt  in  32  operand B
- stall  out  1  hold EX and earlier stages (combinational)
- rdata  out  32  MFHI/MFLO result (combinational)
- md_aluctr  out  5  to mult/div unit: 00110 div, 00111 divu, 01000 mult, 01001 multu, 00000 idle
- md_din1  out  32  latched operand A
- md_din2  out  32  latched operand B
- md_start  out  1  one-cycle divider operand-valid pulse
- md_hi  in  32  unit hi result
- md_lo  in  32  unit lo result
- md_div_done  in  1  divider result valid
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, hi=lo=0, md_din1/2=0, md_aluctr=0, md_start=0, counter=0. Outputs settle on the first edge with reset=1.
- States:
  - IDLE
  - MUL: counter loaded with MUL_LAT-1 at issue, decrements each cycle.
  - DIV: watchdog counter counts up.
- IDLE + ex_valid + MULT/MULTU/DIV/DIVU + !flush: at the edge, latch md_din1=ex_rs, md_din2=ex_rt, drive md_aluctr for the op, go to MUL or DIV. stall=0 in the issue cycle.
- md_start=1 for exactly the first cycle in DIV. It is never re-asserted during the same op.
- md_din1/md_din2/md_aluctr hold stable for the whole MUL/DIV residency and keep their last value after return to IDLE.
- MUL: in the cycle counter==0, capture hi<=md_hi, lo<=md_lo at that edge and go to IDLE. Capture edge = issue edge + MUL_LAT.
- DIV: md_div_done=1 sampled → capture hi/lo, go to IDLE.
  - Divide by zero is not special-cased; the unit's outputs are written as-is.
  - Watchdog reaching DIV_MAX → IDLE, HI/LO unchanged.
- MTHI/MTLO in IDLE: write hi (or lo) from ex_rs at the edge. Visible on hi/lo and rdata from the next cycle.
- MFHI/MFLO in IDLE: rdata = hi (or lo) combinationally; stall=0.
  - rdata = 0 when no MF op is valid.
- stall = ex_valid & busy & (ex_op is any HI/LO op except NONE).
  - Stalled ops are not accepted and are re-presented by EX.
  - Non-HI/LO ops never stall.
- Completion cycle: busy is still 1, so an op presented that cycle stalls once and is accepted the next cycle.
- flush (priority below reset):
  - Any state → IDLE, counter cleared, md_start=0.
  - HI/LO unchanged, even if completion occurs in the same cycle (flush wins).
  - Same-cycle EX op ignored; stall=0 while flush=1.
- Back-to-back issue: a new mult/div is accepted only in IDLE, so issues are ≥ MUL_LAT+1 cycles apart for mults.

Decomposition:
- Package hilo_pkg:
  - hilo_op_t: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - state_t: IDLE, MUL, DIV.
  - aluctr constants: ALU_DIV=5'b00110, ALU_DIVU=5'b00111, ALU_MULT=5'b01000, ALU_MULTU=5'b01001.
- One sub-module, hilo_regfile: HI/LO registers with write-enable muxing between capture and MT writes. The FSM and counter stay in hilo_ctrl.

Test Plan:
- Reset, then MFHI and MFLO → rdata=0, stall=0, busy=0.
- MULT rs=0xFFFFFFFF rt=0x00000002, model drives md_hi/md_lo = 0xFFFFFFFF/0xFFFFFFFE → busy for 5 cycles, capture at issue+5: hi=0xFFFFFFFF, lo=0xFFFFFFFE. MFLO presented at issue+1 stalls until it returns rdata=0xFFFFFFFE.
- DIVU rs=7 rt=2, model asserts md_div_done 20 cycles later with hi=1 lo=3 → md_start high exactly 1 cycle, md_aluctr=00111 held, hi=1, lo=3, then busy=0.
- MTHI 0x12345678 then MFHI next cycle → rdata=0x12345678, no stall; lo unchanged.
- DIV issued, flush at cycle 3, md_div_done at cycle 10 → state IDLE at cycle 4, hi/lo keep their prior values, no capture.
- DIV with md_div_done never asserted → abort after DIV_MAX=40 cycles, busy=0, hi/lo unchanged; a following MULT is accepted.

Source files
------------

// File: rtl/hilo_pkg.sv
// HI/LO controller shared types: operation encoding, FSM states, mult/div unit codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hilo_pkg;

    // EX-stage operation code carried on ex_op
    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } hilo_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    // Operation selects understood by the mult/div datapath
    localparam logic [4:0] ALU_IDLE  = 5'b00000;
    localparam logic [4:0] ALU_DIV   = 5'b00110;
    localparam logic [4:0] ALU_DIVU  = 5'b00111;
    localparam logic [4:0] ALU_MULT  = 5'b01000;
    localparam logic [4:0] ALU_MULTU = 5'b01001;

    function automatic logic [4:0] md_aluctr_of(input hilo_op_t op);
        case (op)
            OP_DIV:   return ALU_DIV;
            OP_DIVU:  return ALU_DIVU;
            OP_MULT:  return ALU_MULT;
            OP_MULTU: return ALU_MULTU;
            default:  return ALU_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/hilo_regfile.sv
// Architectural HI/LO registers; unit-result capture or MTHI/MTLO writes.
// Latency: write visible on hi/lo one cycle after the enabling edge.
// Backpressure: none; the controller guarantees capture and MT writes never coincide.
// Ports: clk/reset; cap_en + cap_hi/cap_lo (result capture); mthi_we/mtlo_we + wdata; hi/lo out.
module hilo_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_en,
    input  logic [31:0] cap_hi,
    input  logic [31:0] cap_lo,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (cap_en) begin
            hi <= cap_hi;
            lo <= cap_lo;
        end else begin
            if (mthi_we) hi <= wdata;
            if (mtlo_we) lo <= wdata;
        end
    end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO issue/writeback controller between EX and the mult/div unit.
// Latency: mult captures MUL_LAT edges after issue; div captures on md_div_done (watchdog DIV_MAX).
// Backpressure: combinational stall on any HI/LO op while busy; flush overrides stall.
// Ports: clk/reset/flush; EX side ex_valid/ex_op/ex_rs/ex_rt -> stall/rdata;
//        unit side md_aluctr/md_din1/md_din2/md_start -> md_hi/md_lo/md_div_done; hi/lo/busy status.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_MAX = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    output logic        stall,
    output logic [31:0] rdata,
    output logic [4:0]  md_aluctr,
    output logic [31:0] md_din1,
    output logic [31:0] md_din2,
    output logic        md_start,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    input  logic        md_div_done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    // Wide enough for both the mult countdown (<=14) and the div watchdog (<DIV_MAX)
    localparam int CNT_W = $clog2(DIV_MAX + 16);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    hilo_op_t op;
    logic     is_hilo;
    logic     is_md;
    logic     is_mul;
    logic     accept;
    logic     issue;
    logic     mthi_we;
    logic     mtlo_we;
    logic     cap_en;

    assign op      = hilo_op_t'(ex_op);
    assign is_hilo = ex_op inside {[4'd1:4'd8]};
    assign is_md   = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    assign is_mul  = op inside {OP_MULT, OP_MULTU};

    assign busy    = (state != IDLE);
    assign stall   = ex_valid & busy & is_hilo & ~flush;

    // Ops are only taken in IDLE; flush discards whatever EX presents this cycle
    assign accept  = ex_valid & ~busy & ~flush;
    assign issue   = accept & is_md;
    assign mthi_we = accept & (op == OP_MTHI);
    assign mtlo_we = accept & (op == OP_MTLO);

    // Flush beats a completion landing in the same cycle
    assign cap_en  = ~flush & (((state == MUL) & (cnt == '0)) |
                               ((state == DIV) & md_div_done));

    always_comb begin
        rdata = '0;
        if (ex_valid && op == OP_MFHI) rdata = hi;
        else if (ex_valid && op == OP_MFLO) rdata = lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            md_din1   <= '0;
            md_din2   <= '0;
            md_aluctr <= ALU_IDLE;
            md_start  <= 1'b0;
        end else if (flush) begin
            // Operands/aluctr deliberately keep their last value
            state    <= IDLE;
            cnt      <= '0;
            md_start <= 1'b0;
        end else begin
            md_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        md_din1   <= ex_rs;
                        md_din2   <= ex_rt;
                        md_aluctr <= md_aluctr_of(op);
                        if (is_mul) begin
                            state <= MUL;
                            cnt   <= CNT_W'(MUL_LAT - 1);
                        end else begin
                            state    <= DIV;
                            cnt      <= '0;
                            md_start <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                DIV: begin
                    // Result beats the watchdog if both land in the same cycle
                    if (md_div_done || cnt == CNT_W'(DIV_MAX - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    hilo_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .cap_en  (cap_en),
        .cap_hi  (md_hi),
        .cap_lo  (md_lo),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .wdata   (ex_rs),
        .hi      (hi),
        .lo      (lo)
    );

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: directed scenarios plus random op stream against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_MAX = 40;

    logic        clk = 1'b0;
    logic        reset, flush, ex_valid;
    logic [3:0]  ex_op;
    logic [31:0] ex_rs, ex_rt;
    logic        stall, md_start, md_div_done, busy;
    logic [31:0] rdata, md_din1, md_din2, md_hi, md_lo, hi, lo;
    logic [4:0]  md_aluctr;

    int n_assert = 0;
    int n_fail   = 0;

    // Architectural HI/LO as the bench believes them to be
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    hilo_ctrl #(.MUL_LAT(MUL_LAT), .DIV_MAX(DIV_MAX)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .stall(stall), .rdata(rdata),
        .md_aluctr(md_aluctr), .md_din1(md_din1), .md_din2(md_din2), .md_start(md_start),
        .md_hi(md_hi), .md_lo(md_lo), .md_div_done(md_div_done),
        .hi(hi), .lo(lo), .busy(busy)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven just after the edge, outputs sampled 1ns later
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] code_of(input logic [3:0] op);
        case (op)
            4'd1:    return 5'b01000;
            4'd2:    return 5'b01001;
            4'd3:    return 5'b00110;
            default: return 5'b00111;
        endcase
    endfunction

    // What an ideal mult/div unit produces for (op, a, b)
    task automatic unit_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] rh, output logic [31:0] rl);
        logic [63:0] p;
        if (op == 4'd1) begin
            p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
            rh = p[63:32]; rl = p[31:0];
        end else if (op == 4'd2) begin
            p = {32'd0, a} * {32'd0, b};
            rh = p[63:32]; rl = p[31:0];
        end else if (b == 32'd0) begin
            rh = a; rl = 32'hFFFF_FFFF;
        end else if (op == 4'd4) begin
            rl = a / b; rh = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            rl = a; rh = 32'd0;
        end else begin
            rl = 32'($signed(a) / $signed(b));
            rh = 32'($signed(a) % $signed(b));
        end
    endtask

    // Issue a mult/div in IDLE. d: cycle (1 = first busy cycle) at which md_div_done pulses,
    // f: cycle at which flush pulses (0 = none), mf: MFHI/MFLO presented from cycle 1 (0 = none).
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int d, input int f, input logic [3:0] mf);
        logic [31:0] rh, rl, nh, nl;
        logic        is_div, cap;
        int          endc, last;
        unit_result(op, a, b, rh, rl);
        is_div = (op == 4'd3) || (op == 4'd4);
        if (!is_div)          begin endc = MUL_LAT; cap = 1'b1; end
        else if (d <= DIV_MAX) begin endc = d;       cap = 1'b1; end
        else                  begin endc = DIV_MAX; cap = 1'b0; end
        if (f != 0 && f <= endc) begin endc = f; cap = 1'b0; end
        last = endc + 1;
        if (is_div && d <= 60 && d + 1 > last) last = d + 1;

        md_hi = rh; md_lo = rl; md_div_done = 1'b0; flush = 1'b0;
        ex_valid = 1'b1; ex_op = op; ex_rs = a; ex_rt = b;
        #1;
        chk1("issue_stall", stall, 1'b0);
        for (int i = 1; i <= last; i++) begin
            next_cycle();
            ex_valid    = (mf != 4'd0) && (i <= endc + 1);
            ex_op       = mf;
            ex_rs       = $urandom;
            flush       = (i == f);
            md_div_done = is_div && (i == d);
            #1;
            nh = (i > endc && cap) ? rh : exp_hi;
            nl = (i > endc && cap) ? rl : exp_lo;
            chk1("busy", busy, i <= endc);
            chk1("stall", stall, (mf != 4'd0) && (i <= endc) && (i != f));
            if (i <= endc) chk1("md_start", md_start, is_div && (i == 1));
            chk32("md_aluctr", {27'd0, md_aluctr}, {27'd0, code_of(op)});
            chk32("md_din1", md_din1, a);
            chk32("md_din2", md_din2, b);
            chk32("hi", hi, nh);
            chk32("lo", lo, nl);
            if (mf != 4'd0 && i == endc + 1)
                chk32("rdata_after_wait", rdata, (mf == 4'd7) ? nh : nl);
        end
        if (cap) begin exp_hi = rh; exp_lo = rl; end
        ex_valid = 1'b0; ex_op = 4'd0; flush = 1'b0; md_div_done = 1'b0;
        next_cycle();
    endtask

    // MTHI/MTLO, then read back with the matching MF op the following cycle
    task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
        flush = 1'b0; ex_valid = 1'b1; ex_op = op; ex_rs = v;
        #1;
        chk1("mt_stall", stall, 1'b0);
        next_cycle();
        if (op == 4'd5) exp_hi = v; else exp_lo = v;
        ex_op = (op == 4'd5) ? 4'd7 : 4'd8;
        ex_rs = $urandom;
        #1;
        chk32("mt_hi", hi, exp_hi);
        chk32("mt_lo", lo, exp_lo);
        chk1("mf_stall", stall, 1'b0);
        chk32("mf_rdata", rdata, v);
        ex_valid = 1'b0; ex_op = 4'd0;
        next_cycle();
    endtask

    initial begin
        logic [3:0] rop, rmf;
        reset = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_op = 4'd0;
        ex_rs = '0; ex_rt = '0; md_hi = '0; md_lo = '0; md_div_done = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        chk32("rst_hi", hi, 32'd0);
        chk32("rst_lo", lo, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_md_start", md_start, 1'b0);
        chk32("rst_md_aluctr", {27'd0, md_aluctr}, 32'd0);
        chk32("rst_md_din1", md_din1, 32'd0);
        chk32("rst_md_din2", md_din2, 32'd0);
        chk32("rdata_idle", rdata, 32'd0);

        ex_valid = 1'b1; ex_op = OP_MFHI; #1;
        chk32("rst_mfhi", rdata, 32'd0);
        chk1("rst_mfhi_stall", stall, 1'b0);
        ex_op = OP_MFLO; #1;
        chk32("rst_mflo", rdata, 32'd0);
        chk1("rst_mflo_stall", stall, 1'b0);
        ex_valid = 1'b0;
        next_cycle();

        // Signed mult with MFLO waiting from issue+1
        run_md(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, OP_MFLO);
        chk32("mult_hi", hi, 32'hFFFF_FFFF);
        chk32("mult_lo", lo, 32'hFFFF_FFFE);

        // DIVU completing 20 cycles after issue
        run_md(OP_DIVU, 32'd7, 32'd2, 20, 0, 4'd0);
        chk32("divu_hi", hi, 32'd1);
        chk32("divu_lo", lo, 32'd3);

        do_mt(OP_MTHI, 32'h1234_5678);

        // Flush during DIV, late done pulse must be ignored
        run_md(OP_DIV, 32'd100, 32'd7, 10, 3, 4'd0);

        // Watchdog abort, then a fresh MULT is taken
        run_md(OP_DIV, 32'd5, 32'd1, 1000, 0, OP_MFHI);
        run_md(OP_MULTU, 32'd3, 32'd4, 0, 0, OP_MFHI);
        chk32("multu_lo", lo, 32'd12);

        // MT presented under flush is discarded
        flush = 1'b1; ex_valid = 1'b1; ex_op = OP_MTLO; ex_rs = 32'hDEAD_BEEF;
        #1;
        chk1("flush_stall", stall, 1'b0);
        next_cycle();
        flush = 1'b0; ex_valid = 1'b0;
        #1;
        chk32("flush_mt_lo", lo, exp_lo);
        next_cycle();

        for (int n = 0; n < 30; n++) begin
            rop = 4'($urandom_range(1, 8));
            if (rop <= 4'd4) begin
                case ($urandom_range(0, 2))
                    0:       rmf = 4'd0;
                    1:       rmf = OP_MFHI;
                    default: rmf = OP_MFLO;
                endcase
                run_md(rop, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                       int'($urandom_range(1, 50)),
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0, rmf);
            end else if (rop <= 4'd6) begin
                do_mt(rop, $urandom);
            end else begin
                ex_valid = 1'b1; ex_op = rop;
                #1;
                chk32("rand_mf", rdata, (rop == 4'd7) ? exp_hi : exp_lo);
                chk1("rand_mf_stall", stall, 1'b0);
                ex_valid = 1'b0;
                next_cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
